// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_e;

    localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
)(
    input  step_mode_e                mode,
    input  logic [2*DATA_WIDTH-1:0]   acc,
    input  logic [DATA_WIDTH-1:0]     operand,
    output logic [2*DATA_WIDTH-1:0]   acc_next
);

    logic [DATA_WIDTH:0] sum_s;
    logic [DATA_WIDTH:0] rem_shift_s;
    logic [DATA_WIDTH:0] diff_s;

    // acc = {high/remainder, multiplier/dividend}; low half shifts out as result bits shift in
    always_comb begin
        sum_s       = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, operand};
        rem_shift_s = {acc[2*DATA_WIDTH-1:DATA_WIDTH], acc[DATA_WIDTH-1]};
        diff_s      = rem_shift_s - {1'b0, operand};
        acc_next    = acc;
        case (mode)
            STEP_MUL: begin
                if (acc[0]) begin
                    acc_next = {sum_s, acc[DATA_WIDTH-1:1]};
                end else begin
                    acc_next = {1'b0, acc[2*DATA_WIDTH-1:1]};
                end
            end
            STEP_DIV: begin
                if (diff_s[DATA_WIDTH]) begin
                    acc_next = {rem_shift_s[DATA_WIDTH-1:0], acc[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    acc_next = {diff_s[DATA_WIDTH-1:0], acc[DATA_WIDTH-2:0], 1'b1};
                end
            end
            default: acc_next = acc;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: operates on magnitudes for DATA_WIDTH cycles,
// then applies sign correction and registers the selected word.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 5
)(
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] srcA_i,
    input  logic [DATA_WIDTH-1:0] srcB_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    muldiv_state_e             state_r, state_next_s;
    muldiv_op_e                op_r, op_in_s;
    logic [CNT_WIDTH-1:0]      cnt_r;
    logic [2*DATA_WIDTH-1:0]   acc_r, acc_step_s, prod_s;
    logic [DATA_WIDTH-1:0]     opb_r, result_r;
    logic [DATA_WIDTH-1:0]     mag_a_s, mag_b_s, quo_s, rem_s;
    logic [DATA_WIDTH-1:0]     fix_result_s, special_result_s;
    logic                      neg_res_r, neg_rem_r;
    logic                      a_signed_s, b_signed_s, sign_a_s, sign_b_s;
    logic                      div_zero_s, div_ovf_s, special_s, accept_s, last_iter_s;
    step_mode_e                step_mode_s;

    // Decode the incoming request: signedness, magnitudes and early-out cases
    always_comb begin
        op_in_s    = muldiv_op_e'(op_i);
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (op_in_s)
            OP_MULH, OP_DIV, OP_REM: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            OP_MULHSU: a_signed_s = 1'b1;
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
        sign_a_s   = a_signed_s & srcA_i[DATA_WIDTH-1];
        sign_b_s   = b_signed_s & srcB_i[DATA_WIDTH-1];
        mag_a_s    = sign_a_s ? -srcA_i : srcA_i;
        mag_b_s    = sign_b_s ? -srcB_i : srcB_i;
        div_zero_s = op_i[2] & (srcB_i == {DATA_WIDTH{1'b0}});
        div_ovf_s  = ((op_in_s == OP_DIV) || (op_in_s == OP_REM)) &&
                     (srcA_i == INT_MIN) && (srcB_i == {DATA_WIDTH{1'b1}});
        special_s  = div_zero_s | div_ovf_s;
        if (div_zero_s) begin
            special_result_s = op_i[1] ? srcA_i : DIV_ZERO_Q;
        end else begin
            special_result_s = op_i[1] ? {DATA_WIDTH{1'b0}} : INT_MIN;
        end
        accept_s = start_i & ~flush_i & ((state_r == ST_IDLE) | (state_r == ST_DONE));
    end

    assign step_mode_s = op_r[2] ? STEP_DIV : STEP_MUL;
    assign last_iter_s = (cnt_r == CNT_WIDTH'(DATA_WIDTH - 1));

    muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .mode     (step_mode_s),
        .acc      (acc_r),
        .operand  (opb_r),
        .acc_next (acc_step_s)
    );

    // Sign correction and output-word selection used in FIX
    always_comb begin
        prod_s = neg_res_r ? -acc_r : acc_r;
        quo_s  = neg_res_r ? -acc_r[DATA_WIDTH-1:0] : acc_r[DATA_WIDTH-1:0];
        rem_s  = neg_rem_r ? -acc_r[2*DATA_WIDTH-1:DATA_WIDTH] : acc_r[2*DATA_WIDTH-1:DATA_WIDTH];
        case (op_r)
            OP_MUL:                      fix_result_s = prod_s[DATA_WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result_s = prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
            OP_DIV, OP_DIVU:             fix_result_s = quo_s;
            OP_REM, OP_REMU:             fix_result_s = rem_s;
            default:                     fix_result_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; flush outranks everything but reset and drops a coincident start
    always_comb begin
        state_next_s = state_r;
        if (flush_i) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        state_next_s = special_s ? ST_DONE : ST_CALC;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (last_iter_s) begin
                        state_next_s = ST_FIX;
                    end else begin
                        state_next_s = ST_CALC;
                    end
                end
                ST_FIX:  state_next_s = ST_DONE;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // Datapath: operand capture, iteration, counter and result register
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            op_r      <= OP_MUL;
            acc_r     <= {(2*DATA_WIDTH){1'b0}};
            opb_r     <= {DATA_WIDTH{1'b0}};
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            cnt_r     <= {CNT_WIDTH{1'b0}};
            result_r  <= {DATA_WIDTH{1'b0}};
        end else if (flush_i) begin
            cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (accept_s) begin
            op_r      <= op_in_s;
            acc_r     <= {{DATA_WIDTH{1'b0}}, mag_a_s};
            opb_r     <= mag_b_s;
            neg_res_r <= sign_a_s ^ sign_b_s;
            neg_rem_r <= sign_a_s;
            cnt_r     <= {CNT_WIDTH{1'b0}};
            if (special_s) begin
                result_r <= special_result_s;
            end
        end else begin
            case (state_r)
                ST_CALC: begin
                    acc_r <= acc_step_s;
                    cnt_r <= cnt_r + CNT_WIDTH'(1);
                end
                ST_FIX:  result_r <= fix_result_s;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign busy_o   = (state_r == ST_CALC) || (state_r == ST_FIX);
    assign done_o   = (state_r == ST_DONE);
    assign result_o = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, special cases, flush,
// ignored start, reset, back-to-back and random ops against a scoreboard.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_result;
    logic [31:0] mon_exp;

    muldiv_unit #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .start_i  (start),
        .op_i     (op),
        .srcA_i   (a),
        .srcB_i   (b),
        .flush_i  (flush),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        longint      sx, sy, ux, uy;
        int          ix, iy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'd0, x};
        uy = {32'd0, y};
        ix = x;
        iy = y;
        model = 32'd0;
        case (o)
            3'd0: begin p = ux * uy; model = p[31:0];  end
            3'd1: begin p = sx * sy; model = p[63:32]; end
            3'd2: begin p = sx * uy; model = p[63:32]; end
            3'd3: begin p = ux * uy; model = p[63:32]; end
            3'd4: model = (y == 32'd0) ? 32'hFFFF_FFFF :
                          ((x == 32'h8000_0000) && (y == 32'hFFFF_FFFF)) ? 32'h8000_0000 : ix / iy;
            3'd5: model = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            3'd6: model = (y == 32'd0) ? x :
                          ((x == 32'h8000_0000) && (y == 32'hFFFF_FFFF)) ? 32'd0 : ix % iy;
            default: model = (y == 32'd0) ? x : x % y;
        endcase
    endfunction

    // Scoreboard: every done pulse pops one expected result
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_eq("result", result, mon_exp);
                last_result = mon_exp;
            end
        end
    end

    // Issue one operation, check latency, busy profile and one-cycle done pulse.
    // glitch>0 pulses a junk start in that CALC cycle, which must be ignored.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] expv, input int glitch);
        int   lat;
        int   busy_bad;
        int   exp_lat;
        logic special;
        lat      = 0;
        busy_bad = 0;
        special  = o[2] && ((y == 32'd0) || (!o[0] && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF)));
        exp_lat  = special ? 1 : 34;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        exp_q.push_back(expv);
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) lat = k;
            else if (busy !== !special) busy_bad++;
            if (k == glitch) begin
                start = 1'b1; op = 3'b111; a = $urandom; b = 32'd3;
            end
        end
        check_eq("latency", lat, exp_lat);
        check_eq("busy_profile", busy_bad, 32'd0);
        check_eq("busy_in_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_eq("done_pulse", {31'd0, done}, 32'd0);
        check_eq("result_hold", result, last_result);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d1, d2, dcnt;
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        rstn = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        last_result = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        rstn = 1'b1;

        do_op(3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
        do_op(3'd5, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 0);
        do_op(3'd7, 32'd7,         32'd2,         32'd1,         0);
        do_op(3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 0);
        do_op(3'd6, 32'd5,         32'd0,         32'd5,         0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);
        do_op(3'd4, 32'd100,       32'd7,         32'd14,        5);

        // Flush at CALC cycle 10 with a coincident start that must be dropped
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("busy_before_flush", {31'd0, busy}, 32'd1);
        flush = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; start = 1'b0;
        @(negedge clk);
        check_eq("flush_busy", {31'd0, busy}, 32'd0);
        check_eq("flush_done", {31'd0, done}, 32'd0);
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check_eq("flush_no_done", dcnt, 32'd0);
        check_eq("flush_result", result, last_result);

        // Start in IDLE coincident with flush is dropped
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'd5; b = 32'd0;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check_eq("flush_start_busy", {31'd0, busy}, 32'd0);
        check_eq("flush_start_done", {31'd0, done}, 32'd0);

        // Reset in CALC cycle 20
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_done", {31'd0, done}, 32'd0);
        check_eq("midrst_result", result, 32'd0);
        rstn = 1'b1;
        last_result = 32'd0;

        // Back-to-back: start held high through DONE
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
        exp_q.push_back(32'd42);
        @(posedge clk);
        #1 op = 3'd5; a = 32'd100; b = 32'd7;
        exp_q.push_back(32'd14);
        d1 = 0; d2 = 0;
        for (int k = 1; k <= 100 && d2 == 0; k++) begin
            @(negedge clk);
            if (d1 != 0 && k == d1 + 1) begin
                start = 1'b0;
                check_eq("b2b_no_bubble", {31'd0, busy}, 32'd1);
            end
            if (done) begin
                if (d1 == 0) d1 = k;
                else d2 = k;
            end
        end
        start = 1'b0;
        check_eq("b2b_first_lat", d1, 32'd34);
        check_eq("b2b_second_lat", d2 - d1, 32'd34);

        for (int i = 0; i < 10; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            do_op(ro, rx, ry, model(ro, rx, ry), 0);
        end

        check_eq("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
